// File: rtl/mpmc_pkg.sv
// Shared types and helpers for the round-robin multi-port memory controller.
package mpmc_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BUSY      = 2'd1,
      LOW_POWER = 2'd2
   } mpmc_state_t;

   function automatic int calc_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mpmc_rr_arbiter.sv
// Combinational round-robin picker: first requesting port at or after ptr, wrapping upward.
module mpmc_rr_arbiter #(
   parameter  int NPORTS = 2,
   localparam int PW     = $clog2(NPORTS)
) (
   input  logic [NPORTS-1:0] req_i,
   input  logic [PW-1:0]     ptr_i,
   output logic [NPORTS-1:0] gnt_o,
   output logic [PW-1:0]     idx_o,
   output logic              valid_o
);

   logic [PW:0] cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int i = 0; i < NPORTS; i++) begin
         // ptr + i is below 2*NPORTS, so a single subtraction gives the modulo
         cand = {1'b0, ptr_i} + (PW+1)'(i);
         if (cand >= (PW+1)'(NPORTS)) begin
            cand = cand - (PW+1)'(NPORTS);
         end
         if (!valid_o && req_i[cand[PW-1:0]]) begin
            valid_o              = 1'b1;
            idx_o                = cand[PW-1:0];
            gnt_o[cand[PW-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mpmc_rr_ctrl.sv
// N-port round-robin controller onto a local register-file memory, with fixed access
// latency and an idle-timeout low-power state.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for requests; counts idle cycles toward LOW_POWER
//   BUSY      | serving the latched access for LATENCY cycles
//   LOW_POWER | asleep after TIMEOUT idle cycles; any req wakes to IDLE
module mpmc_rr_ctrl
   import mpmc_pkg::*;
#(
   parameter  int NPORTS  = 2,
   parameter  int DW      = 8,
   parameter  int DEPTH   = 16,
   parameter  int LATENCY = 2,
   parameter  int TIMEOUT = 10,
   localparam int AW      = calc_aw(DEPTH),
   localparam int PW      = $clog2(NPORTS)
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [NPORTS-1:0]    req_i,
   input  logic [NPORTS-1:0]    rw_i,
   input  logic [NPORTS*AW-1:0] addr_i,
   input  logic [NPORTS*DW-1:0] wdata_i,
   output logic [NPORTS-1:0]    grant_o,
   output logic [NPORTS-1:0]    rvalid_o,
   output logic [DW-1:0]        rdata_o,
   output logic                 busy_o,
   output logic                 low_power_o
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   mpmc_state_t       state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [TW-1:0]     idle_q, idle_d;
   logic [NPORTS-1:0] grant_q, grant_d;
   logic [NPORTS-1:0] rvalid_q, rvalid_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              busy_q, busy_d;
   logic              lp_q, lp_d;
   logic [PW-1:0]     port_q, port_d;
   logic              rw_q, rw_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic              mem_we;

   logic [DW-1:0]     mem_q [DEPTH];

   logic [NPORTS-1:0] arb_gnt;
   logic [PW-1:0]     arb_idx;
   logic              arb_valid;

   mpmc_rr_arbiter #(.NPORTS(NPORTS)) u_arb (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      idle_d   = idle_q;
      grant_d  = '0;
      rvalid_d = '0;
      rdata_d  = rdata_q;
      port_d   = port_q;
      rw_d     = rw_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      mem_we   = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               grant_d = arb_gnt;
               port_d  = arb_idx;
               rw_d    = rw_i[arb_idx];
               addr_d  = addr_i[int'(arb_idx)*AW +: AW];
               wdata_d = wdata_i[int'(arb_idx)*DW +: DW];
               ptr_d   = (arb_idx == PW'(NPORTS-1)) ? '0 : arb_idx + PW'(1);
               idle_d  = '0;
               cnt_d   = '0;
               state_d = BUSY;
            end else if (idle_q == TW'(TIMEOUT-1)) begin
               state_d = LOW_POWER;
            end else begin
               idle_d = idle_q + TW'(1);
            end
         end
         BUSY: begin
            if (cnt_q == CW'(LATENCY-1)) begin
               state_d = IDLE;
               if (rw_q) begin
                  mem_we = 1'b1;
               end else begin
                  rdata_d          = mem_q[addr_q];
                  rvalid_d[port_q] = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         LOW_POWER: begin
            // wake cycle only; the grant comes from IDLE on the next edge
            if (|req_i) begin
               state_d = IDLE;
               idle_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == BUSY);
      lp_d   = (state_d == LOW_POWER);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         cnt_q    <= '0;
         idle_q   <= '0;
         grant_q  <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         busy_q   <= 1'b0;
         lp_q     <= 1'b0;
         port_q   <= '0;
         rw_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         idle_q   <= idle_d;
         grant_q  <= grant_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
         lp_q     <= lp_d;
         port_q   <= port_d;
         rw_q     <= rw_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   // storage is not reset; a reset on the commit edge drops the write
   always_ff @(posedge clk_i) begin
      if (rst_n_i && mem_we) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign grant_o     = grant_q;
   assign rvalid_o    = rvalid_q;
   assign rdata_o     = rdata_q;
   assign busy_o      = busy_q;
   assign low_power_o = lp_q;

endmodule

// File: tb/tb_mpmc_rr_ctrl.sv
// Bench for mpmc_rr_ctrl: two configurations, directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_mpmc_rr_ctrl;

   localparam int A_NP = 4, A_DW = 8,  A_DEPTH = 16, A_LAT = 2, A_TO = 10, A_AW = 4;
   localparam int B_NP = 2, B_DW = 16, B_DEPTH = 64, B_LAT = 1, B_TO = 10, B_AW = 6;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic                 a_rst_n;
   logic [A_NP-1:0]      a_req, a_rw, a_grant, a_rvalid;
   logic [A_NP*A_AW-1:0] a_addr;
   logic [A_NP*A_DW-1:0] a_wdata;
   logic [A_DW-1:0]      a_rdata;
   logic                 a_busy, a_lp;

   logic                 b_rst_n;
   logic [B_NP-1:0]      b_req, b_rw, b_grant, b_rvalid;
   logic [B_NP*B_AW-1:0] b_addr;
   logic [B_NP*B_DW-1:0] b_wdata;
   logic [B_DW-1:0]      b_rdata;
   logic                 b_busy, b_lp;

   mpmc_rr_ctrl #(.NPORTS(A_NP), .DW(A_DW), .DEPTH(A_DEPTH), .LATENCY(A_LAT), .TIMEOUT(A_TO)) u_dut_a (
      .clk_i(clk), .rst_n_i(a_rst_n), .req_i(a_req), .rw_i(a_rw), .addr_i(a_addr),
      .wdata_i(a_wdata), .grant_o(a_grant), .rvalid_o(a_rvalid), .rdata_o(a_rdata),
      .busy_o(a_busy), .low_power_o(a_lp)
   );

   mpmc_rr_ctrl #(.NPORTS(B_NP), .DW(B_DW), .DEPTH(B_DEPTH), .LATENCY(B_LAT), .TIMEOUT(B_TO)) u_dut_b (
      .clk_i(clk), .rst_n_i(b_rst_n), .req_i(b_req), .rw_i(b_rw), .addr_i(b_addr),
      .wdata_i(b_wdata), .grant_o(b_grant), .rvalid_o(b_rvalid), .rdata_o(b_rdata),
      .busy_o(b_busy), .low_power_o(b_lp)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int sel      = 0;

   bit rst_in;
   int s_req [4];
   int s_rw  [4];
   int s_addr[4];
   int s_wd  [4];

   // reference model: remaining-busy countdown, sleep flag, quiet-run length, rotating pointer
   int m_np, m_lat, m_to, m_amask, m_dmask;
   int m_busy_left, m_quiet, m_ptr;
   bit m_sleep;
   int t_port, t_rw, t_addr, t_wd;
   int mem[64];
   bit wr [64];
   int e_grant, e_rvalid, e_rdata, e_busy, e_lp;
   bit e_rdata_known;

   int o_grant, o_rvalid, o_rdata, o_busy, o_lp;

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic use_config(input int s);
      sel = s;
      if (s == 0) begin
         m_np = A_NP; m_lat = A_LAT; m_to = A_TO; m_amask = A_DEPTH - 1; m_dmask = 'hFF;
      end else begin
         m_np = B_NP; m_lat = B_LAT; m_to = B_TO; m_amask = B_DEPTH - 1; m_dmask = 'hFFFF;
      end
      for (int i = 0; i < 64; i++) begin
         wr[i] = 1'b0; mem[i] = 0;
      end
      for (int i = 0; i < 4; i++) begin
         s_req[i] = 0; s_rw[i] = 0; s_addr[i] = 0; s_wd[i] = 0;
      end
   endtask

   task automatic drive();
      a_rst_n = (sel == 0) ? rst_in : 1'b0;
      b_rst_n = (sel == 1) ? rst_in : 1'b0;
      for (int i = 0; i < A_NP; i++) begin
         a_req[i]                = (sel == 0) && (s_req[i] != 0);
         a_rw[i]                 = (sel == 0) && (s_rw[i] != 0);
         a_addr[i*A_AW +: A_AW]  = (sel == 0) ? A_AW'(s_addr[i]) : '0;
         a_wdata[i*A_DW +: A_DW] = (sel == 0) ? A_DW'(s_wd[i]) : '0;
      end
      for (int i = 0; i < B_NP; i++) begin
         b_req[i]                = (sel == 1) && (s_req[i] != 0);
         b_rw[i]                 = (sel == 1) && (s_rw[i] != 0);
         b_addr[i*B_AW +: B_AW]  = (sel == 1) ? B_AW'(s_addr[i]) : '0;
         b_wdata[i*B_DW +: B_DW] = (sel == 1) ? B_DW'(s_wd[i]) : '0;
      end
   endtask

   task automatic model_step();
      int k;
      bit any;
      e_grant  = 0;
      e_rvalid = 0;
      any = 1'b0;
      for (int i = 0; i < m_np; i++) if (s_req[i] != 0) any = 1'b1;
      if (!rst_in) begin
         m_busy_left = 0; m_sleep = 1'b0; m_quiet = 0; m_ptr = 0;
         e_rdata = 0; e_rdata_known = 1'b1;
      end else if (m_busy_left > 0) begin
         m_busy_left--;
         if (m_busy_left == 0) begin
            if (t_rw != 0) begin
               mem[t_addr] = t_wd; wr[t_addr] = 1'b1;
            end else begin
               e_rvalid      = 1 << t_port;
               e_rdata       = mem[t_addr];
               e_rdata_known = wr[t_addr];
            end
         end
      end else if (m_sleep) begin
         if (any) begin
            m_sleep = 1'b0; m_quiet = 0;
         end
      end else if (any) begin
         k = -1;
         for (int j = 0; j < m_np; j++) begin
            int p;
            p = (m_ptr + j) % m_np;
            if (k < 0 && s_req[p] != 0) k = p;
         end
         e_grant = 1 << k;
         t_port = k; t_rw = s_rw[k]; t_addr = s_addr[k] & m_amask; t_wd = s_wd[k] & m_dmask;
         m_ptr = (k + 1) % m_np;
         m_quiet = 0;
         m_busy_left = m_lat;
      end else if (m_quiet == m_to - 1) begin
         m_sleep = 1'b1;
      end else begin
         m_quiet++;
      end
      e_busy = (m_busy_left > 0) ? 1 : 0;
      e_lp   = m_sleep ? 1 : 0;
   endtask

   task automatic tick();
      drive();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      o_grant  = (sel == 0) ? int'(a_grant)  : int'(b_grant);
      o_rvalid = (sel == 0) ? int'(a_rvalid) : int'(b_rvalid);
      o_rdata  = (sel == 0) ? int'(a_rdata)  : int'(b_rdata);
      o_busy   = (sel == 0) ? int'(a_busy)   : int'(b_busy);
      o_lp     = (sel == 0) ? int'(a_lp)     : int'(b_lp);
      chk("grant", o_grant, e_grant);
      chk("rvalid", o_rvalid, e_rvalid);
      chk("busy", o_busy, e_busy);
      chk("low_power", o_lp, e_lp);
      if (e_rdata_known) chk("rdata", o_rdata, e_rdata);
   endtask

   task automatic post(input int p, input int rw, input int addr, input int wd);
      s_req[p] = 1; s_rw[p] = rw; s_addr[p] = addr & m_amask; s_wd[p] = wd & m_dmask;
   endtask

   task automatic rand_traffic(input int ncyc, input int density);
      for (int n = 0; n < ncyc; n++) begin
         for (int p = 0; p < m_np; p++) begin
            if (s_req[p] == 0 && $urandom_range(99) < density)
               post(p, int'($urandom_range(1)), int'($urandom), int'($urandom));
         end
         rst_in = ($urandom_range(249) != 0);
         tick();
         for (int p = 0; p < m_np; p++) if (e_grant[p]) s_req[p] = 0;
      end
      rst_in = 1'b1;
   endtask

   initial begin
      int ng, last_g;

      // configuration A: 4 ports, latency 2, 16 x 8
      use_config(0);
      rst_in = 1'b0;
      tick(); tick();
      chk("rst_grant", o_grant, 0);
      chk("rst_rdata", o_rdata, 0);
      chk("rst_busy", o_busy, 0);
      rst_in = 1'b1;

      // write then read of the same address from another port
      post(0, 1, 3, 'hA5);
      tick();
      chk("t1_grant0", o_grant, 1);
      s_req[0] = 0;
      post(1, 0, 3, 0);
      repeat (A_LAT) tick();
      tick();
      chk("t1_grant1", o_grant, 2);
      s_req[1] = 0;
      repeat (A_LAT) tick();
      chk("t1_rvalid1", o_rvalid, 2);
      chk("t1_rdata", o_rdata, 'hA5);

      // write whose requester lets go right after its grant still lands
      post(1, 1, 9, 'h5A);
      tick();
      chk("t6_grant1", o_grant, 2);
      s_req[1] = 0;
      repeat (A_LAT) tick();
      post(3, 0, 9, 0);
      tick();
      chk("t6_grant3", o_grant, 8);
      s_req[3] = 0;
      repeat (A_LAT) tick();
      chk("t6_rvalid3", o_rvalid, 8);
      chk("t6_rdata", o_rdata, 'h5A);

      // all ports requesting continuously
      rst_in = 1'b0; tick(); rst_in = 1'b1;
      for (int p = 0; p < A_NP; p++) post(p, int'($urandom_range(1)), int'($urandom), int'($urandom));
      ng = 0; last_g = 0;
      for (int n = 0; n < 60 && ng < 12; n++) begin
         tick();
         if (o_grant != 0) begin
            chk("t2_order", o_grant, 1 << (ng % A_NP));
            if (ng > 0) chk("t2_spacing", cyc - last_g, A_LAT + 1);
            last_g = cyc;
            ng++;
         end
         for (int p = 0; p < A_NP; p++)
            if (e_grant[p]) post(p, int'($urandom_range(1)), int'($urandom), int'($urandom));
      end
      chk("t2_count", ng, 12);

      // idle timeout and wake
      for (int p = 0; p < 4; p++) s_req[p] = 0;
      rst_in = 1'b0; tick(); rst_in = 1'b1;
      repeat (A_TO - 1) tick();
      chk("t3_lp_before", o_lp, 0);
      tick();
      chk("t3_lp_on", o_lp, 1);
      tick();
      chk("t3_lp_hold", o_lp, 1);
      post(2, 1, 12, 'h77);
      tick();
      chk("t3_lp_off", o_lp, 0);
      chk("t3_no_grant", o_grant, 0);
      tick();
      chk("t3_grant2", o_grant, 4);
      s_req[2] = 0;
      repeat (A_LAT) tick();

      // reset during a write aborts it
      post(0, 1, 7, 'h11);
      tick();
      s_req[0] = 0;
      repeat (A_LAT) tick();
      post(1, 1, 7, 'h3C);
      tick();
      chk("t4_grant1", o_grant, 2);
      s_req[1] = 0;
      rst_in = 1'b0;
      tick();
      chk("t4_rst_grant", o_grant, 0);
      chk("t4_rst_busy", o_busy, 0);
      chk("t4_rst_rvalid", o_rvalid, 0);
      chk("t4_rst_rdata", o_rdata, 0);
      rst_in = 1'b1;
      post(2, 0, 7, 0);
      tick();
      chk("t4_grant2", o_grant, 4);
      s_req[2] = 0;
      repeat (A_LAT) tick();
      chk("t4_rvalid2", o_rvalid, 4);
      chk("t4_rdata_old", o_rdata, 'h11);

      rand_traffic(200, 40);
      rand_traffic(150, 3);
      rand_traffic(150, 90);

      // configuration B: 2 ports, latency 1, 64 x 16
      use_config(1);
      rst_in = 1'b0;
      tick(); tick();
      rst_in = 1'b1;
      post(0, 1, 0, 'h1234);
      tick();
      chk("t5_grant_w0", o_grant, 1);
      s_req[0] = 0;
      repeat (B_LAT) tick();
      post(0, 1, 63, 'hBEEF);
      tick();
      chk("t5_grant_w63", o_grant, 1);
      s_req[0] = 0;
      repeat (B_LAT) tick();
      post(1, 0, 63, 0);
      tick();
      chk("t5_grant_r63", o_grant, 2);
      s_req[1] = 0;
      repeat (B_LAT) tick();
      chk("t5_rvalid63", o_rvalid, 2);
      chk("t5_rdata63", o_rdata, 'hBEEF);
      post(0, 0, 0, 0);
      tick();
      s_req[0] = 0;
      repeat (B_LAT) tick();
      chk("t5_rvalid0", o_rvalid, 1);
      chk("t5_rdata0", o_rdata, 'h1234);

      rand_traffic(300, 50);
      rand_traffic(100, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
